univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 4, meaning number of register stages; legal range 2..32.
REQ-002 Parameter CNT_W, default $clog2(WIDTH), meaning shift-counter width; minimum 1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 mode  input  2  operation select: 00 hold, 01 shift-up, 10 shift-down, 11 parallel load.
REQ-006 si  input  1  serial data in, used by both shift modes.
REQ-007 pdata  input  WIDTH  parallel load data.
REQ-008 q  output  WIDTH  parallel register contents, registered.
REQ-009 so_up  output  1  serial out for shift-up, equal to q[WIDTH-1].
REQ-010 so_dn  output  1  serial out for shift-down, equal to q[0].
REQ-011 cnt  output  CNT_W  shifts completed in current frame, registered.
REQ-012 frame_done  output  1  one-cycle pulse marking completion of WIDTH shifts.

Function
REQ-013 Hold (00) SHALL keep q, cnt unchanged and drive frame_done 0 on the next edge.
REQ-014 Shift-up (01) SHALL set q[0] <= si and q[i] <= q[i-1] for i = 1..WIDTH-1 each edge.
REQ-015 Shift-down (10) SHALL set q[WIDTH-1] <= si and q[i] <= q[i+1] for i = 0..WIDTH-2 each edge.
REQ-016 Load (11) SHALL set q <= pdata, cnt <= 0, frame_done <= 0 in one edge.
REQ-017 Serial latency SHALL be WIDTH edges: a bit sampled on si appears on the opposite-end serial output after the WIDTH-th shift edge in one direction.
REQ-018 On every shift edge with cnt < WIDTH-1, cnt SHALL increment by 1 and frame_done SHALL be 0.
REQ-019 On a shift edge with cnt == WIDTH-1, cnt SHALL wrap to 0 and frame_done SHALL be 1 for exactly that following cycle.
REQ-020 frame_done SHALL be 0 after every edge not covered by REQ-019.
REQ-021 Shift-up and shift-down edges SHALL both advance cnt; a direction change SHALL NOT clear cnt.
REQ-022 Hold cycles between shifts SHALL preserve cnt, so shifts need not be consecutive to complete a frame.
REQ-023 so_up and so_dn SHALL be pure wires from q with no additional register stage.

Reset
REQ-024 rst low SHALL immediately, without a clock edge, force q = 0, cnt = 0, frame_done = 0.
REQ-025 Reset asserted mid-frame SHALL discard partial count; a full WIDTH shifts after release is required for the next frame_done.
REQ-026 The first edge with rst high SHALL perform the operation selected by mode.

Structure
REQ-027 Mode encodings (HOLD, UP, DN, LOAD) SHALL be constants in shared package univ_shift_reg_pkg, used by RTL and bench.
REQ-028 One sub-module usr_stage SHALL implement a single bit: 4:1 mode mux plus async-active-low-reset flip-flop, instantiated WIDTH times via generate.
REQ-029 The shift counter and frame_done logic SHALL reside in univ_shift_reg, not in usr_stage.

Verification (WIDTH=4)
REQ-030 Reset: rst=0 with q previously 4'b1111 -> q=0, cnt=0, frame_done=0 before next clk edge.
REQ-031 Shift-up si=1,0,0,0 over 4 edges -> q=0001,0010,0100,1000; so_up=1 and frame_done=1 after edge 4 only; cnt=0.
REQ-032 Load pdata=4'b1011, then shift-down si=0 for 4 edges -> q=0101,0010,0001,0000; so_dn=1,1,0,1 sampled before each edge; frame_done after edge 4.
REQ-033 Two shift-up, three hold, two shift-down -> cnt=1,2,2,2,2,3,0; frame_done high only after the final edge.
REQ-034 Three shifts (cnt=3), then load -> cnt=0, frame_done stays 0; four more shifts required for pulse.
REQ-035 Two shifts, rst pulse low 3 ns mid-cycle -> q=0, cnt=0 immediately; four further shifts produce frame_done, not two.

Source files
------------

// File: rtl/univ_shift_reg_pkg.sv
// Shared constants for the universal shift register: mode encodings used by
// both the datapath and anything driving it.
package univ_shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DN   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  function automatic logic is_shift(logic [1:0] m);
    return (m == MODE_UP) || (m == MODE_DN);
  endfunction

endpackage

// File: rtl/usr_stage.sv
// One bit of the universal shift register: 4:1 mode mux feeding a flop
// with asynchronous active-low clear.
module usr_stage
  import univ_shift_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       from_lo,
  input  logic       from_hi,
  input  logic       pd,
  output logic       q
);

  logic d;

  always_comb begin
    d = q;
    case (mode)
      MODE_UP:   d = from_lo;
      MODE_DN:   d = from_hi;
      MODE_LOAD: d = pd;
      default:   d = q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= 1'b0;
    else      q <= d;
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift-up / shift-down / parallel load,
// with a frame counter that pulses frame_done every WIDTH shifts.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             si,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] q,
  output logic             so_up,
  output logic             so_dn,
  output logic [CNT_W-1:0] cnt,
  output logic             frame_done
);

  // Each stage sees its lower neighbour (shift-up source) and upper
  // neighbour (shift-down source); si enters at whichever end is open.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic lo, hi;
    if (i == 0) begin : g_lo_si
      assign lo = si;
    end else begin : g_lo_q
      assign lo = q[i-1];
    end
    if (i == WIDTH-1) begin : g_hi_si
      assign hi = si;
    end else begin : g_hi_q
      assign hi = q[i+1];
    end
    usr_stage u_stage (
      .clk     (clk),
      .rst     (rst),
      .mode    (mode),
      .from_lo (lo),
      .from_hi (hi),
      .pd      (pdata[i]),
      .q       (q[i])
    );
  end

  assign so_up = q[WIDTH-1];
  assign so_dn = q[0];

  logic last;
  assign last = (cnt == CNT_W'(WIDTH-1));

  // Either shift direction advances the frame; hold freezes it, load clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (mode == MODE_LOAD) begin
        cnt <= '0;
      end else if (is_shift(mode)) begin
        if (last) begin
          cnt        <= '0;
          frame_done <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=4): table-driven vectors
// through a scoreboard queue, plus hand-written reset sequences.
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       mode;
  logic             si;
  logic [WIDTH-1:0] pdata;
  logic [WIDTH-1:0] q;
  logic             so_up, so_dn;
  logic [CNT_W-1:0] cnt;
  logic             frame_done;

  univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .si(si), .pdata(pdata),
    .q(q), .so_up(so_up), .so_dn(so_dn), .cnt(cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       mode;
    logic             si;
    logic [WIDTH-1:0] pdata;
    logic [WIDTH-1:0] exp_q;
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_fd;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] cnt;
    logic             fd;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t v(logic [1:0] m, logic s, logic [WIDTH-1:0] pd,
                             logic [WIDTH-1:0] eq, logic [CNT_W-1:0] ec, logic ef);
    vec_t r;
    r.mode = m; r.si = s; r.pdata = pd;
    r.exp_q = eq; r.exp_cnt = ec; r.exp_fd = ef;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input exp_t e);
    chk({tag, ".q"},     32'(q),          32'(e.q));
    chk({tag, ".cnt"},   32'(cnt),        32'(e.cnt));
    chk({tag, ".fd"},    32'(frame_done), 32'(e.fd));
    chk({tag, ".so_up"}, 32'(so_up),      32'(e.q[WIDTH-1]));
    chk({tag, ".so_dn"}, 32'(so_dn),      32'(e.q[0]));
  endtask

  // Drive on the falling edge, push expectation, compare 1 ns after the rising edge.
  task automatic apply(input string tag, input vec_t t);
    exp_t e, got;
    @(negedge clk);
    mode = t.mode; si = t.si; pdata = t.pdata;
    e.q = t.exp_q; e.cnt = t.exp_cnt; e.fd = t.exp_fd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check_state(tag, got);
    end
  endtask

  task automatic rst_pulse_check(input string tag);
    exp_t z;
    z.q = '0; z.cnt = '0; z.fd = 1'b0;
    @(negedge clk);
    mode = MODE_HOLD;
    #1 rst = 1'b0;
    #1 check_state(tag, z);
    #2 rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t z;
    z.q = '0; z.cnt = '0; z.fd = 1'b0;
    rst = 1'b0; mode = MODE_HOLD; si = 1'b0; pdata = '0;
    #3;
    check_state("reset_init", z);
    #10 rst = 1'b1;

    // shift-up one bit through, frame_done only after 4th edge
    tbl.push_back(v(MODE_UP,   1, 4'h0, 4'b0001, 1, 0));
    tbl.push_back(v(MODE_UP,   0, 4'h0, 4'b0010, 2, 0));
    tbl.push_back(v(MODE_UP,   0, 4'h0, 4'b0100, 3, 0));
    tbl.push_back(v(MODE_UP,   0, 4'h0, 4'b1000, 0, 1));
    // load then shift-down; so_dn follows 1,1,0,1
    tbl.push_back(v(MODE_LOAD, 0, 4'b1011, 4'b1011, 0, 0));
    tbl.push_back(v(MODE_DN,   0, 4'h0, 4'b0101, 1, 0));
    tbl.push_back(v(MODE_DN,   0, 4'h0, 4'b0010, 2, 0));
    tbl.push_back(v(MODE_DN,   0, 4'h0, 4'b0001, 3, 0));
    tbl.push_back(v(MODE_DN,   0, 4'h0, 4'b0000, 0, 1));
    // up, up, hold x3, down, down: holds keep cnt, direction change keeps cnt
    tbl.push_back(v(MODE_UP,   1, 4'h0, 4'b0001, 1, 0));
    tbl.push_back(v(MODE_UP,   1, 4'h0, 4'b0011, 2, 0));
    tbl.push_back(v(MODE_HOLD, 0, 4'hf, 4'b0011, 2, 0));
    tbl.push_back(v(MODE_HOLD, 1, 4'hf, 4'b0011, 2, 0));
    tbl.push_back(v(MODE_HOLD, 0, 4'hf, 4'b0011, 2, 0));
    tbl.push_back(v(MODE_DN,   0, 4'h0, 4'b0001, 3, 0));
    tbl.push_back(v(MODE_DN,   0, 4'h0, 4'b0000, 0, 1));
    // three shifts, load clears cnt, four more needed
    tbl.push_back(v(MODE_UP,   1, 4'h0, 4'b0001, 1, 0));
    tbl.push_back(v(MODE_UP,   1, 4'h0, 4'b0011, 2, 0));
    tbl.push_back(v(MODE_UP,   1, 4'h0, 4'b0111, 3, 0));
    tbl.push_back(v(MODE_LOAD, 0, 4'b1010, 4'b1010, 0, 0));
    tbl.push_back(v(MODE_UP,   0, 4'h0, 4'b0100, 1, 0));
    tbl.push_back(v(MODE_UP,   0, 4'h0, 4'b1000, 2, 0));
    tbl.push_back(v(MODE_UP,   0, 4'h0, 4'b0000, 3, 0));
    tbl.push_back(v(MODE_UP,   1, 4'h0, 4'b0001, 0, 1));
    tbl.push_back(v(MODE_HOLD, 0, 4'h0, 4'b0001, 0, 0));

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // async reset with q=1111, observed before any edge
    apply("load_ones", v(MODE_LOAD, 0, 4'b1111, 4'b1111, 0, 0));
    rst_pulse_check("reset_async");

    // two shifts, reset mid-cycle, then a full four shifts for the pulse
    apply("pre_rst0", v(MODE_UP, 1, 4'h0, 4'b0001, 1, 0));
    apply("pre_rst1", v(MODE_UP, 1, 4'h0, 4'b0011, 2, 0));
    rst_pulse_check("reset_mid");
    apply("post_rst0", v(MODE_DN, 1, 4'h0, 4'b1000, 1, 0));
    apply("post_rst1", v(MODE_DN, 1, 4'h0, 4'b1100, 2, 0));
    apply("post_rst2", v(MODE_DN, 0, 4'h0, 4'b0110, 3, 0));
    apply("post_rst3", v(MODE_DN, 0, 4'h0, 4'b0011, 0, 1));

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
